nmea_parser: RTL and testbench

NMEA_PARSER -- requirements
Module: nmea_parser

---
 rtl/nmea_pkg.sv | 46 ++++
 rtl/nmea_dec_accum.sv | 24 ++
 rtl/nmea_parser.sv | 200 ++++++++++++++++++++
 tb/tb_nmea_parser.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/nmea_pkg.sv
// Shared types, ASCII constants and helpers for the NMEA-0183 sentence parser.
package nmea_pkg;

  typedef enum logic [2:0] {IDLE, HDR, BODY, CS_HI, CS_LO, COMMIT} state_t;
  typedef enum logic [1:0] {T_OTHER, T_GGA, T_VTG} stype_t;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_NINE   = 8'h39;
  localparam logic [7:0] CH_N      = 8'h4E;
  localparam logic [7:0] CH_E      = 8'h45;

  localparam logic [7:0] F_TIME  = 8'd1;
  localparam logic [7:0] F_LAT   = 8'd2;
  localparam logic [7:0] F_NS    = 8'd3;
  localparam logic [7:0] F_LON   = 8'd4;
  localparam logic [7:0] F_EW    = 8'd5;
  localparam logic [7:0] F_FIX   = 8'd6;
  localparam logic [7:0] F_SPEED = 8'd7;

  // Bit 4 flags a valid hex digit; bits 3:0 carry its value.
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

  function automatic logic [47:0] pow10(input logic [2:0] n);
    case (n)
      3'd1:    return 48'd10;
      3'd2:    return 48'd100;
      3'd3:    return 48'd1000;
      3'd4:    return 48'd10000;
      3'd5:    return 48'd100000;
      default: return 48'd1;
    endcase
  endfunction

endpackage

// File: rtl/nmea_dec_accum.sv
// Digit-serial decimal accumulator: value = value*10 + digit, saturating at all-ones.
module nmea_dec_accum #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             digit_en,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] value
);
  logic [WIDTH+4:0] next_val;

  always_comb begin
    next_val = ({5'd0, value} * (WIDTH+5)'(10)) + (WIDTH+5)'(digit);
  end

  always_ff @(posedge clk) begin
    if (rst || clear)
      value <= '0;
    else if (digit_en)
      value <= (next_val > (WIDTH+5)'({WIDTH{1'b1}})) ? {WIDTH{1'b1}} : next_val[WIDTH-1:0];
  end
endmodule

// File: rtl/nmea_parser.sv
// Streaming NMEA-0183 decoder: GGA time/position/fix and VTG speed, published
// from shadow registers only when the sentence checksum matches.
module nmea_parser
  import nmea_pkg::*;
#(
  parameter int MAX_LEN     = 82,
  parameter int FRAC_DIGITS = 4,
  parameter int TIMEOUT     = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_new,
  input  logic [7:0]  rx_data,
  output logic        fix_valid,
  output logic [23:0] utc_bcd,
  output logic [6:0]  lat_deg,
  output logic [23:0] lat_submins,
  output logic        lat_north,
  output logic [7:0]  lon_deg,
  output logic [23:0] lon_submins,
  output logic        lon_east,
  output logic [15:0] speed_kmh_x100,
  output logic        sentence_ok,
  output logic        csum_err,
  output logic        abort
);
  localparam int LW = $clog2(MAX_LEN + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] FRAC_N = 3'(FRAC_DIGITS);

  state_t        state;
  stype_t        stype;
  logic [7:0]    csum, cs_rx, field;
  logic [3:0]    cs_hi;
  logic [LW-1:0] len, len_next;
  logic [TW-1:0] idle_cnt;
  logic [2:0]    hdr_cnt, int_cnt, lat_fd, lon_fd, spd_fd, utc_n;
  logic [23:0]   hdr_sh, utc_sh;
  logic          seen_dot, field_first, ns_sh, ew_sh, fix_sh;

  logic          is_dollar, is_star, is_comma, is_dot, is_dig, active;
  logic          start, restart, len_over, timeout_hit;
  logic          field_char, int_dig, frac_dig;
  logic          lat_deg_en, lat_min_en, lon_deg_en, lon_min_en, spd_en;
  logic [4:0]    hex;
  logic [6:0]    lat_deg_sh;
  logic [7:0]    lon_deg_sh;
  logic [23:0]   lat_min_sh, lon_min_sh;
  logic [15:0]   spd_sh;
  logic [47:0]   lat_scaled, lon_scaled, spd_scaled;

  always_comb begin
    is_dollar   = rx_data == CH_DOLLAR;
    is_star     = rx_data == CH_STAR;
    is_comma    = rx_data == CH_COMMA;
    is_dot      = rx_data == CH_DOT;
    is_dig      = rx_data >= CH_ZERO && rx_data <= CH_NINE;
    hex         = hex_nibble(rx_data);
    active      = state inside {HDR, BODY, CS_HI, CS_LO};
    restart     = rx_new && is_dollar && active;
    start       = rx_new && is_dollar && (active || state == IDLE);
    len_next    = len + LW'(1);
    len_over    = rx_new && !is_dollar && (state == HDR || state == BODY) && len_next > LW'(MAX_LEN);
    timeout_hit = !rx_new && active && idle_cnt == TW'(TIMEOUT - 1);
    field_char  = rx_new && state == BODY && !is_dollar && !is_star && !is_comma && !len_over;
    int_dig     = field_char && is_dig && !seen_dot;
    frac_dig    = field_char && is_dig && seen_dot;
    lat_deg_en  = field == F_LAT && int_dig && int_cnt < 3'd2;
    lat_min_en  = field == F_LAT && ((int_dig && int_cnt >= 3'd2) || (frac_dig && lat_fd < FRAC_N));
    lon_deg_en  = field == F_LON && int_dig && int_cnt < 3'd3;
    lon_min_en  = field == F_LON && ((int_dig && int_cnt >= 3'd3) || (frac_dig && lon_fd < FRAC_N));
    spd_en      = field == F_SPEED && (int_dig || (frac_dig && spd_fd < 3'd2));
    // Missing fraction digits are zero-padded by scaling at commit time.
    lat_scaled  = 48'(lat_min_sh) * pow10(FRAC_N - lat_fd);
    lon_scaled  = 48'(lon_min_sh) * pow10(FRAC_N - lon_fd);
    spd_scaled  = 48'(spd_sh) * pow10(3'd2 - spd_fd);
  end

  nmea_dec_accum #(.WIDTH(7))  u_lat_deg (.clk(clk), .rst(rst), .clear(start), .digit_en(lat_deg_en),
                                          .digit(rx_data[3:0]), .value(lat_deg_sh));
  nmea_dec_accum #(.WIDTH(24)) u_lat_min (.clk(clk), .rst(rst), .clear(start), .digit_en(lat_min_en),
                                          .digit(rx_data[3:0]), .value(lat_min_sh));
  nmea_dec_accum #(.WIDTH(8))  u_lon_deg (.clk(clk), .rst(rst), .clear(start), .digit_en(lon_deg_en),
                                          .digit(rx_data[3:0]), .value(lon_deg_sh));
  nmea_dec_accum #(.WIDTH(24)) u_lon_min (.clk(clk), .rst(rst), .clear(start), .digit_en(lon_min_en),
                                          .digit(rx_data[3:0]), .value(lon_min_sh));
  nmea_dec_accum #(.WIDTH(16)) u_speed   (.clk(clk), .rst(rst), .clear(start), .digit_en(spd_en),
                                          .digit(rx_data[3:0]), .value(spd_sh));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE; stype <= T_OTHER; csum <= '0; cs_rx <= '0; cs_hi <= '0; field <= '0;
      len <= '0; idle_cnt <= '0; hdr_cnt <= '0; hdr_sh <= '0; int_cnt <= '0;
      lat_fd <= '0; lon_fd <= '0; spd_fd <= '0; utc_n <= '0; utc_sh <= '0;
      seen_dot <= 1'b0; field_first <= 1'b0; ns_sh <= 1'b0; ew_sh <= 1'b0; fix_sh <= 1'b0;
      fix_valid <= 1'b0; utc_bcd <= '0; lat_deg <= '0; lat_submins <= '0; lat_north <= 1'b0;
      lon_deg <= '0; lon_submins <= '0; lon_east <= 1'b0; speed_kmh_x100 <= '0;
      sentence_ok <= 1'b0; csum_err <= 1'b0; abort <= 1'b0;
    end else begin
      sentence_ok <= 1'b0;
      csum_err    <= 1'b0;
      abort       <= 1'b0;
      idle_cnt    <= (rx_new || !active) ? '0 : idle_cnt + TW'(1);
      if (timeout_hit) begin
        abort <= 1'b1;
        state <= IDLE;
      end else if (start) begin
        abort <= restart;
        state <= HDR; csum <= '0; len <= LW'(1); hdr_cnt <= '0; field <= '0; int_cnt <= '0;
        seen_dot <= 1'b0; field_first <= 1'b0; lat_fd <= '0; lon_fd <= '0; spd_fd <= '0;
        utc_n <= '0; utc_sh <= '0; ns_sh <= 1'b0; ew_sh <= 1'b0; fix_sh <= 1'b0;
      end else if (len_over) begin
        abort <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          HDR: if (rx_new) begin
            len  <= len_next;
            csum <= csum ^ rx_data;
            if (hdr_cnt != 3'd5) begin
              hdr_sh  <= {hdr_sh[15:0], rx_data};
              hdr_cnt <= hdr_cnt + 3'd1;
            end else if (is_comma) begin
              state <= BODY; field <= 8'd1; field_first <= 1'b1;
              stype <= (hdr_sh == "GGA") ? T_GGA : (hdr_sh == "VTG") ? T_VTG : T_OTHER;
            end else begin
              abort <= 1'b1;
              state <= IDLE;
            end
          end
          BODY: if (rx_new) begin
            len <= len_next;
            if (is_star) begin
              state <= CS_HI;
            end else begin
              csum <= csum ^ rx_data;
              if (is_comma) begin
                if (field != 8'hFF) field <= field + 8'd1;
                int_cnt <= '0; seen_dot <= 1'b0; field_first <= 1'b1;
              end else begin
                field_first <= 1'b0;
                if (is_dot) seen_dot <= 1'b1;
                if (int_dig && int_cnt != 3'd7) int_cnt <= int_cnt + 3'd1;
                if (lat_min_en && frac_dig) lat_fd <= lat_fd + 3'd1;
                if (lon_min_en && frac_dig) lon_fd <= lon_fd + 3'd1;
                if (spd_en && frac_dig) spd_fd <= spd_fd + 3'd1;
                if (field == F_TIME && is_dig && utc_n != 3'd6) begin
                  utc_sh <= {utc_sh[19:0], rx_data[3:0]};
                  utc_n  <= utc_n + 3'd1;
                end
                if (field == F_NS) ns_sh <= rx_data == CH_N;
                if (field == F_EW) ew_sh <= rx_data == CH_E;
                if (field == F_FIX && field_first) fix_sh <= rx_data != CH_ZERO;
              end
            end
          end
          CS_HI: if (rx_new) begin
            if (hex[4]) begin
              cs_hi <= hex[3:0];
              state <= CS_LO;
            end else begin
              csum_err <= 1'b1;
              state    <= IDLE;
            end
          end
          CS_LO: if (rx_new) begin
            if (hex[4]) begin
              cs_rx <= {cs_hi, hex[3:0]};
              state <= COMMIT;
            end else begin
              csum_err <= 1'b1;
              state    <= IDLE;
            end
          end
          COMMIT: begin
            state <= IDLE;
            if (cs_rx == csum) begin
              sentence_ok <= 1'b1;
              if (stype == T_GGA) begin
                fix_valid   <= fix_sh;
                utc_bcd     <= utc_sh;
                lat_deg     <= lat_deg_sh;
                lat_submins <= (lat_scaled > 48'hFFFFFF) ? 24'hFFFFFF : lat_scaled[23:0];
                lat_north   <= ns_sh;
                lon_deg     <= lon_deg_sh;
                lon_submins <= (lon_scaled > 48'hFFFFFF) ? 24'hFFFFFF : lon_scaled[23:0];
                lon_east    <= ew_sh;
              end
              if (stype == T_VTG)
                speed_kmh_x100 <= (spd_scaled > 48'hFFFF) ? 16'hFFFF : spd_scaled[15:0];
            end else begin
              csum_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nmea_parser.sv
// Scoreboard bench for nmea_parser: stimulus pushes expected events, a monitor pops and checks.
module tb_nmea_parser;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_new = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        probe = 1'b0;
  logic        fix_valid, lat_north, lon_east, sentence_ok, csum_err, abort;
  logic [23:0] utc_bcd, lat_submins, lon_submins;
  logic [6:0]  lat_deg;
  logic [7:0]  lon_deg;
  logic [15:0] speed_kmh_x100;

  localparam int K_OK = 0, K_CSUM = 1, K_ABORT = 2, K_SNAP = 3;

  typedef struct packed {
    logic fix; logic [23:0] utc; logic [6:0] ld; logic [23:0] ls; logic ln;
    logic [7:0] od; logic [23:0] os; logic oe; logic [15:0] spd;
  } outs_t;
  typedef struct { int kind; outs_t o; int at_char; int at_stall; } exp_t;

  exp_t  q[$];
  outs_t cur = '0;
  int    n_cmp = 0, n_bad = 0, sent = 0, stall = 0;

  nmea_parser #(.MAX_LEN(82), .FRAC_DIGITS(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .rx_new(rx_new), .rx_data(rx_data),
    .fix_valid(fix_valid), .utc_bcd(utc_bcd), .lat_deg(lat_deg), .lat_submins(lat_submins),
    .lat_north(lat_north), .lon_deg(lon_deg), .lon_submins(lon_submins), .lon_east(lon_east),
    .speed_kmh_x100(speed_kmh_x100), .sentence_ok(sentence_ok), .csum_err(csum_err), .abort(abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) stall <= rx_new ? 0 : stall + 1;

  task automatic expect_ev(input int kind, input int at_char, input int at_stall);
    exp_t e;
    e.kind = kind; e.o = cur; e.at_char = at_char; e.at_stall = at_stall;
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_new = 1'b1; rx_data = b;
    sent = (b == 8'h24) ? 1 : sent + 1;
    @(posedge clk); #1;
    rx_new = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic pulse_probe();
    @(posedge clk); #1 probe = 1'b1;
    @(posedge clk); #1 probe = 1'b0;
  endtask

  function automatic string build(input string body, input bit lower);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < body.len(); i++) x = x ^ body[i];
    return lower ? $sformatf("$%s*%02x", body, x) : $sformatf("$%s*%02X", body, x);
  endfunction

  // Monitor: every status pulse or probe consumes one scoreboard entry.
  initial begin
    int    act_kind;
    outs_t act;
    exp_t  e;
    forever begin
      @(negedge clk);
      if (probe || sentence_ok || csum_err || abort) begin
        act_kind = sentence_ok ? K_OK : csum_err ? K_CSUM : abort ? K_ABORT : K_SNAP;
        act = {fix_valid, utc_bcd, lat_deg, lat_submins, lat_north, lon_deg, lon_submins,
               lon_east, speed_kmh_x100};
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_event: got kind %0d, required no event", act_kind);
        end else begin
          e = q.pop_front();
          n_cmp++;
          if (act_kind != e.kind) begin
            n_bad++;
            $display("FAIL event_kind: got %0d required %0d", act_kind, e.kind);
          end
          n_cmp++;
          if (act != e.o) begin
            n_bad++;
            $display("FAIL outputs(kind %0d): got %h required %h", e.kind, act, e.o);
          end
          if (e.at_char >= 0) begin
            n_cmp++;
            if (sent != e.at_char) begin
              n_bad++;
              $display("FAIL abort_char: got %0d required %0d", sent, e.at_char);
            end
          end
          if (e.at_stall >= 0) begin
            n_cmp++;
            if (stall != e.at_stall) begin
              n_bad++;
              $display("FAIL timeout_cycle: got %0d required %0d", stall, e.at_stall);
            end
          end
          $display("txn kind=%0d outputs=%h", act_kind, act);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string gga1, vtg1, gga2;
    gga1 = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47";
    vtg1 = "$GPVTG,054.7,T,034.4,M,005.5,N,010.2,K*48";
    gga2 = build("GPGGA,000102,0130.123456,S,12345.6789,W,,08,0.9,545.4,M,46.9,M,,", 1'b0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    expect_ev(K_SNAP, -1, -1);
    pulse_probe();

    // GGA reference sentence with padding of a 3-digit fraction
    cur.fix = 1'b1; cur.utc = 24'h123519; cur.ld = 7'd48; cur.ls = 24'd70380; cur.ln = 1'b1;
    cur.od = 8'd11; cur.os = 24'd310000; cur.oe = 1'b1;
    expect_ev(K_OK, -1, -1);
    send_str(gga1);

    cur.spd = 16'd1020;
    expect_ev(K_OK, -1, -1);
    send_str(vtg1);

    expect_ev(K_CSUM, -1, -1);
    send_str("$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*48");

    // Unknown type with lower-case checksum: accepted, nothing published
    expect_ev(K_OK, -1, -1);
    send_str(build("GPRMC,225446,4916.45,N,12311.12,W,000.5", 1'b1));

    // Extra fraction digits dropped, exact digits kept, empty fix field, S/W hemispheres
    cur.fix = 1'b0; cur.utc = 24'h000102; cur.ld = 7'd1; cur.ls = 24'd301234; cur.ln = 1'b0;
    cur.od = 8'd123; cur.os = 24'd456789; cur.oe = 1'b0;
    expect_ev(K_OK, -1, -1);
    send_str(gga2);

    cur.spd = 16'd65535;
    expect_ev(K_OK, -1, -1);
    send_str(build("GNVTG,,T,,M,,N,999.99,K", 1'b0));

    expect_ev(K_CSUM, -1, -1);
    send_str("$GPGGA,1*4G");

    // Over-length sentence aborts at char 83, then a good sentence still parses
    expect_ev(K_ABORT, 83, -1);
    send_str("$GPGGA,");
    for (int i = 0; i < 90; i++) send_byte(8'h37);
    cur.fix = 1'b1; cur.utc = 24'h123519; cur.ld = 7'd48; cur.ls = 24'd70380; cur.ln = 1'b1;
    cur.od = 8'd11; cur.os = 24'd310000; cur.oe = 1'b1;
    expect_ev(K_OK, -1, -1);
    send_str(gga1);

    // '$' mid-sentence restarts at the new header
    expect_ev(K_ABORT, 1, -1);
    send_str("$GPGGA,0930,48");
    cur.fix = 1'b0; cur.utc = 24'h000102; cur.ld = 7'd1; cur.ls = 24'd301234; cur.ln = 1'b0;
    cur.od = 8'd123; cur.os = 24'd456789; cur.oe = 1'b0;
    expect_ev(K_OK, -1, -1);
    send_str(gga2);

    // Reset mid-body clears everything; later bytes without '$' are ignored
    send_str("$GPGGA,1235");
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cur = '0;
    expect_ev(K_SNAP, -1, -1);
    pulse_probe();
    send_str("GPGGA,123519,*47");

    // Stall mid-sentence: abort on the 100th idle cycle
    expect_ev(K_ABORT, -1, 100);
    send_str("$GPGGA,1234");
    repeat (110) @(posedge clk);
    cur.spd = 16'd1020;
    expect_ev(K_OK, -1, -1);
    send_str(vtg1);

    repeat (4) @(posedge clk);
    expect_ev(K_SNAP, -1, -1);
    pulse_probe();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
